// File: rtl/exp_led_pwm.sv
// exp_led_pwm: 8-channel breathing LED PWM with a phase-staggered triangle ramp and exponential brightness.
// Optional EXP_LED_PWM_UIO_DEBUG_EN drives registered channel-0 level onto uio_out.
module exp_led_pwm #(
    parameter int NCH      = 8,
    parameter int PWM_BITS = 12,
    parameter int ACC_BITS = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [7:0]     ui_in,
    output logic [NCH-1:0] uo_out,
    input  logic [7:0]     uio_in,
    output logic [7:0]     uio_out,
    output logic [7:0]     uio_oe
);

    localparam int IDX_BITS = 9;
    localparam int PH_STEP  = (1 << IDX_BITS) / NCH;

    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]      pwm_q, pwm_d;
    logic [7:0]          lin [NCH];
    logic [PWM_BITS-1:0] duty [NCH];
    logic                unused_in;

    assign unused_in = ^{ena, uio_in};

    // Fold the 9-bit phase into a 0..255..0 triangle.
    function automatic logic [7:0] tri_lin(input logic [IDX_BITS-1:0] idx);
        return idx[8] ? ~idx[7:0] : idx[7:0];
    endfunction

    // Piecewise exponential: 3-bit exponent, 5-bit mantissa with hidden one.
    function automatic logic [PWM_BITS-1:0] exp_duty(input logic [7:0] lv);
        logic [PWM_BITS:0] t;
        t      = '0;
        t[5:0] = {1'b1, lv[4:0]};
        t      = t << lv[7:5];
        return (lv == 8'd0) ? '0 : t[PWM_BITS:1];
    endfunction

    always_comb begin
        acc_d = acc_q + ACC_BITS'(ui_in);
        cnt_d = cnt_q + 1'b1;
        pwm_d = '0;
        for (int i = 0; i < NCH; i++) begin
            lin[i]   = tri_lin(acc_q[ACC_BITS-1 -: IDX_BITS] + IDX_BITS'(i * PH_STEP));
            duty[i]  = exp_duty(lin[i]);
            pwm_d[i] = duty[i] > cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            pwm_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign uo_out = pwm_q;

`ifdef EXP_LED_PWM_UIO_DEBUG_EN
    logic [7:0] dbg_q, dbg_d;

    always_comb begin
        dbg_d = lin[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign uio_out = dbg_q;
    assign uio_oe  = 8'hFF;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_exp_led_pwm.sv
// tb_exp_led_pwm: cycle-by-cycle comparison of exp_led_pwm against an arithmetic model,
// plus PWM high-time measurements at frozen ramp points.
module tb_exp_led_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    int unsigned acc_m;
    int          cnt_m;
    int          hi0;
    int          hi1;

    exp_led_pwm dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Brightness of channel ch at ramp position acc: position on a 512-step
    // circle, folded into a triangle.
    function automatic int m_lin(input int unsigned acc, input int ch);
        int pos;
        pos = ((acc >> 15) + ch * 64) % 512;
        return (pos < 256) ? pos : 511 - pos;
    endfunction

    function automatic int m_duty(input int lv);
        if (lv == 0) return 0;
        return ((32 + lv % 32) * (1 << (lv / 32))) / 2;
    endfunction

    task automatic step(input logic r, input logic [7:0] u);
        logic [7:0] exp_uo;
        logic [7:0] exp_dbg;
        rst    = r;
        ui_in  = u;
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
        exp_uo  = '0;
        exp_dbg = '0;
        if (!r) begin
            for (int ch = 0; ch < 8; ch++)
                exp_uo[ch] = m_duty(m_lin(acc_m, ch)) > cnt_m;
            exp_dbg = 8'(m_lin(acc_m, 0));
        end
        if (r) begin
            acc_m = 0;
            cnt_m = 0;
        end else begin
            acc_m = (acc_m + u) & 32'h00FF_FFFF;
            cnt_m = (cnt_m + 1) % 4096;
        end
        @(posedge clk);
        #1;
        chk("uo_out", 32'(uo_out), 32'(exp_uo));
`ifdef EXP_LED_PWM_UIO_DEBUG_EN
        chk("uio_out", 32'(uio_out), 32'(exp_dbg));
        chk("uio_oe", 32'(uio_oe), 32'hFF);
`else
        chk("uio_out", 32'(uio_out), 32'(8'h00 & exp_dbg));
        chk("uio_oe", 32'(uio_oe), 32'h00);
`endif
        if (uo_out[0] === 1'b1) hi0++;
        if (uo_out[1] === 1'b1) hi1++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [7:0] u);
        for (int k = 0; k < n; k++) step(1'b0, u);
    endtask

    task automatic measure(output int h0, output int h1);
        hi0 = 0;
        hi1 = 0;
        run(4096, 8'd0);
        h0 = hi0;
        h1 = hi1;
    endtask

    initial begin
        int h0, h1;
        int exp128;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'd128;
        uio_in = 8'h00;
        acc_m  = 0;
        cnt_m  = 0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) step(1'b1, 8'd128);
        chk("reset_uo", 32'(uo_out), 32'h00);
        chk("reset_dbg", 32'(uio_out), 32'h00);
        step(1'b0, 8'd128);
        chk("first_fe", 32'(uo_out), 32'hFE);

        step(1'b1, 8'd0);
        measure(h0, h1);
        chk("frozen_ch0_hi", 32'(h0), 32'd0);
        chk("frozen_ch1_hi", 32'(h1), 32'd64);

        run(256, 8'd128);
        measure(h0, h1);
        chk("lin1_hi", 32'(h0), 32'd16);

        run(16321, 8'd255);
        exp128 = m_duty(128);
        measure(h0, h1);
        chk("lin128_hi", 32'(h0), 32'(exp128));

        run(16320, 8'd255);
        measure(h0, h1);
        chk("lin255_hi", 32'(h0), 32'd4032);

        run(33100, 8'd255);
        chk("wrapped", 32'(acc_m < 32'd8000000), 32'd1);
        step(1'b1, 8'd255);
        chk("midrun_rst", 32'(uo_out), 32'h00);
        step(1'b0, 8'd255);
        chk("midrun_fe", 32'(uo_out), 32'hFE);

        for (int k = 0; k < 2000; k++)
            step(($urandom_range(0, 99) < 2), 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
